// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus start/busy/done multi-step shift, one position per clock.
// Define UNIV_SHIFT_ARITH_EN to make mode 11 an arithmetic right shift; otherwise it repeats mode 01.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   input  logic [1:0]       mode,
   input  logic             ser_in,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic [WIDTH-1:0] d_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

   logic [0:0]       state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] amount_sat;
   logic [1:0]       mode_q;
   logic             fill_q;
   logic [WIDTH-1:0] step_d;
   logic             step_out;

   assign amount_sat = (amount > WIDTH_C) ? WIDTH_C : amount;

   // One shift position using the mode and fill captured at start.
   always_comb begin
      step_d   = d_out;
      step_out = 1'b0;
      case (mode_q)
         2'b00: begin
            step_d   = {d_out[WIDTH-2:0], fill_q};
            step_out = d_out[WIDTH-1];
         end
         2'b10: begin
            step_d   = {d_out[WIDTH-2:0], d_out[WIDTH-1]};
            step_out = d_out[WIDTH-1];
         end
`ifdef UNIV_SHIFT_ARITH_EN
         2'b11: begin
            step_d   = {d_out[WIDTH-1], d_out[WIDTH-1:1]};
            step_out = d_out[0];
         end
         default: begin
            step_d   = {fill_q, d_out[WIDTH-1:1]};
            step_out = d_out[0];
         end
`else
         default: begin
            step_d   = {fill_q, d_out[WIDTH-1:1]};
            step_out = d_out[0];
         end
`endif
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count   <= '0;
         mode_q  <= 2'b00;
         fill_q  <= 1'b0;
         d_out   <= '0;
         ser_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  d_out <= d_in;
               end else if (start) begin
                  mode_q <= mode;
                  fill_q <= ser_in;
                  if (amount_sat == '0) begin
                     done <= 1'b1;
                  end else begin
                     count <= amount_sat;
                     busy  <= 1'b1;
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               // A load aborts the sequence silently: no done pulse.
               if (load) begin
                  d_out <= d_in;
                  count <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  d_out   <= step_d;
                  ser_out <= step_out;
                  count   <= count - CNT_W'(1);
                  if (count == CNT_W'(1)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomized checks of univ_shift_reg against a whole-shift arithmetic reference model.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] d_in = 8'h00;
   logic [1:0] mode = 2'b00;
   logic       ser_in = 1'b0;
   logic       start = 1'b0;
   logic [3:0] amount = 4'd0;
   logic [7:0] d_out;
   logic       ser_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int fails = 0;

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .load(load), .d_in(d_in), .mode(mode),
      .ser_in(ser_in), .start(start), .amount(amount), .d_out(d_out),
      .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Result of shifting v by n positions in one go: {last bit out, register}.
   function automatic logic [8:0] model(input int v, input int m, input int f, input int n);
      int d, s, sv, mm;
      mm = m;
`ifndef UNIV_SHIFT_ARITH_EN
      if (mm == 3) mm = 1;
`endif
      case (mm)
         0: begin
            d = ((v << n) | (f != 0 ? ((1 << n) - 1) : 0)) & 255;
            s = (v >> (8 - n)) & 1;
         end
         1: begin
            d = (v >> n) | (f != 0 ? (255 & ~(255 >> n)) : 0);
            s = (v >> (n - 1)) & 1;
         end
         2: begin
            d = ((v << n) | (v >> (8 - n))) & 255;
            s = (v >> (8 - n)) & 1;
         end
         default: begin
            sv = (v >= 128) ? v - 256 : v;
            d = (sv >>> n) & 255;
            s = (v >> (n - 1)) & 1;
         end
      endcase
      return {s[0], d[7:0]};
   endfunction

   task automatic do_op(input logic [7:0] v, input logic [1:0] m, input logic f,
                        input logic [3:0] amt, output logic [7:0] fd, output logic fs);
      int n;
      logic [8:0] e;
      load = 1'b1; d_in = v; start = 1'b0;
      tick();
      chk("load_d", 32'(d_out), 32'(v));
      chk("load_busy", 32'(busy), 0);
      load = 1'b0; start = 1'b1; mode = m; ser_in = f; amount = amt;
      tick();
      start = 1'b0;
      mode = 2'($urandom_range(0, 3)); ser_in = 1'($urandom_range(0, 1));
      amount = 4'($urandom_range(0, 15));
      n = (int'(amt) > 8) ? 8 : int'(amt);
      fd = d_out; fs = ser_out;
      if (n == 0) begin
         chk("zero_done", 32'(done), 1);
         chk("zero_busy", 32'(busy), 0);
         chk("zero_d", 32'(d_out), 32'(v));
         tick();
         chk("zero_done_clr", 32'(done), 0);
         chk("zero_busy2", 32'(busy), 0);
      end else begin
         chk("start_busy", 32'(busy), 1);
         chk("start_done", 32'(done), 0);
         chk("start_d", 32'(d_out), 32'(v));
         for (int i = 1; i <= n; i++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            e = model(int'(v), int'(m), int'(f), i);
            chk("step_d", 32'(d_out), 32'(e[7:0]));
            chk("step_ser", 32'(ser_out), 32'(e[8]));
            chk("step_busy", 32'(busy), (i < n) ? 1 : 0);
            chk("step_done", 32'(done), (i == n) ? 1 : 0);
         end
         fd = d_out; fs = ser_out;
         tick();
         chk("done_clr", 32'(done), 0);
         chk("idle_busy", 32'(busy), 0);
         chk("idle_d", 32'(d_out), 32'(fd));
      end
   endtask

   initial begin
      logic [7:0] fd;
      logic       fs;

      #2;
      chk("rst_d", 32'(d_out), 0);
      chk("rst_ser", 32'(ser_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      tick();
      reset_n = 1'b1;
      tick();

      do_op(8'hA5, 2'b00, 1'b1, 4'd3, fd, fs);
      chk("a5_final", 32'(fd), 32'h2F);
      chk("a5_ser", 32'(fs), 1);

      do_op(8'h81, 2'b10, 1'b0, 4'd8, fd, fs);
      chk("rot8", 32'(fd), 32'h81);
      do_op(8'h81, 2'b10, 1'b0, 4'd12, fd, fs);
      chk("rot12_sat", 32'(fd), 32'h81);

      do_op(8'h90, 2'b11, 1'b0, 4'd2, fd, fs);
`ifdef UNIV_SHIFT_ARITH_EN
      chk("asr_90", 32'(fd), 32'hE4);
`else
      chk("asr_90", 32'(fd), 32'h24);
`endif

      do_op(8'h5A, 2'b01, 1'b1, 4'd0, fd, fs);
      chk("zero_keep", 32'(fd), 32'h5A);

      // Abort: start 5 steps, start re-asserted on first busy cycle, load on the second.
      load = 1'b1; d_in = 8'hF0; tick();
      load = 1'b0; start = 1'b1; mode = 2'b00; ser_in = 1'b0; amount = 4'd5; tick();
      amount = 4'd1; tick();
      chk("busy_restart_ign", 32'(busy), 1);
      chk("busy_step1", 32'(d_out), 32'hE0);
      start = 1'b0; load = 1'b1; d_in = 8'h3C; tick();
      load = 1'b0;
      chk("abort_d", 32'(d_out), 32'h3C);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      tick();
      chk("abort_done2", 32'(done), 0);
      chk("abort_hold", 32'(d_out), 32'h3C);

      // Load and start in the same idle cycle: load wins.
      load = 1'b1; start = 1'b1; d_in = 8'hC3; amount = 4'd4; tick();
      load = 1'b0; start = 1'b0;
      chk("ls_d", 32'(d_out), 32'hC3);
      chk("ls_busy", 32'(busy), 0);
      tick();
      chk("ls_busy2", 32'(busy), 0);
      chk("ls_done", 32'(done), 0);
      chk("ls_hold", 32'(d_out), 32'hC3);

      // Back-to-back: a start in the done cycle is accepted.
      start = 1'b1; mode = 2'b10; amount = 4'd1; tick();
      chk("b2b_busy1", 32'(busy), 1);
      tick();
      chk("b2b_done1", 32'(done), 1);
      chk("b2b_d1", 32'(d_out), 32'h87);
      mode = 2'b01; ser_in = 1'b1; amount = 4'd1; tick();
      start = 1'b0;
      chk("b2b_busy2", 32'(busy), 1);
      chk("b2b_done_clr", 32'(done), 0);
      tick();
      chk("b2b_d2", 32'(d_out), 32'hC3);
      chk("b2b_ser2", 32'(fs | ser_out), 1);
      tick();

      for (int k = 0; k < 40; k++) begin
         do_op(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), fd, fs);
      end

      // Asynchronous reset in the middle of a shift.
      load = 1'b1; d_in = 8'hFF; tick();
      load = 1'b0; start = 1'b1; mode = 2'b00; ser_in = 1'b1; amount = 4'd8; tick();
      start = 1'b0; tick(); tick();
      reset_n = 1'b0;
      #2;
      chk("mid_rst_d", 32'(d_out), 0);
      chk("mid_rst_ser", 32'(ser_out), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_d", 32'(d_out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
